// File: rtl/add_round_key_stage.sv
// add_round_key_stage
//   Round-output stage that sits directly after mix_cols in the AES encrypt
//   datapath. Each accepted beat is registered as state ^ round_key into a
//   2-entry buffer with a valid/ready handshake. The stage tracks the round
//   number within each block. On round NR it takes the pre-MixColumns state
//   and marks the beat as the final ciphertext.
//
// Parameters
//   NR         rounds per block (10/12/14 for AES-128/192/256), range 1..15
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   upstream beat valid
//   in_ready   stage can accept a beat (buffer not full)
//   in_start   beat is round 1 of a new block
//   in_mix     [127:0] state after mix_cols
//   in_nomix   [127:0] state before mix_cols (after shift_rows)
//   in_key     [127:0] round key for this beat
//   out_valid  output beat valid (buffer not empty)
//   out_ready  downstream accepts
//   out_data   [127:0] state ^ key of the head beat
//   out_round  [3:0] round number of out_data (1..NR)
//   out_last   out_data is the final ciphertext (round NR)
//   err_seq    sticky sequencing error flag, cleared only by reset
module add_round_key_stage #(
  parameter int unsigned NR = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_start,
  input  logic [127:0] in_mix,
  input  logic [127:0] in_nomix,
  input  logic [127:0] in_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic [3:0]   out_round,
  output logic         out_last,
  output logic         err_seq
);

  localparam logic [3:0] NR_L = 4'(NR);

  // Buffer occupancy and pointers
  logic [1:0]   count_q, count_d;
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;

  // Buffer storage
  logic [127:0] data_q  [2];
  logic [3:0]   round_q [2];
  logic         last_q  [2];

  // Round tracking: 0 = idle, otherwise the round expected on the next beat
  logic [3:0]   exp_round_q, exp_round_d;
  logic         err_seq_q, err_seq_d;

  // Incoming beat, fully formed before it is written into the buffer
  logic         push, pop;
  logic [3:0]   beat_round;
  logic         beat_last;
  logic [127:0] beat_data;

  // Handshake flags come straight from the occupancy register
  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);

  assign push = in_valid  & in_ready;
  assign pop  = out_valid & out_ready;

  // Head entry drives the outputs; it cannot change until it is popped
  // because writes only ever target the other slot while it is occupied.
  assign out_data  = data_q[rd_ptr_q];
  assign out_round = round_q[rd_ptr_q];
  assign out_last  = last_q[rd_ptr_q];
  assign err_seq   = err_seq_q;

  // Round classification of the incoming beat. A start beat, or an
  // unexpected non-start beat while idle, both begin a fresh block at
  // round 1; the next expected round then follows from that beat.
  always_comb begin
    beat_round  = 4'd1;
    exp_round_d = exp_round_q;
    err_seq_d   = err_seq_q;
    if (push) begin
      if (in_start) begin
        if (exp_round_q != 4'd0) begin
          err_seq_d = 1'b1;
        end
      end else if (exp_round_q == 4'd0) begin
        err_seq_d = 1'b1;
      end else begin
        beat_round = exp_round_q;
      end
      exp_round_d = (beat_round == NR_L) ? 4'd0 : beat_round + 4'd1;
    end
  end

  // Final round skips MixColumns: use the shift_rows output instead
  always_comb begin
    beat_last = (beat_round == NR_L);
    beat_data = (beat_last ? in_nomix : in_mix) ^ in_key;
  end

  // Occupancy and pointer updates; 1-bit pointers wrap naturally
  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      wr_ptr_d = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q     <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      exp_round_q <= '0;
      err_seq_q   <= 1'b0;
      for (int unsigned i = 0; i < 2; i++) begin
        data_q[i]  <= '0;
        round_q[i] <= '0;
        last_q[i]  <= 1'b0;
      end
    end else begin
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      exp_round_q <= exp_round_d;
      err_seq_q   <= err_seq_d;
      if (push) begin
        data_q[wr_ptr_q]  <= beat_data;
        round_q[wr_ptr_q] <= beat_round;
        last_q[wr_ptr_q]  <= beat_last;
      end
    end
  end

endmodule

// File: tb/tb_add_round_key_stage.sv
// tb_add_round_key_stage
//   Self-checking bench for add_round_key_stage (NR=10). A queue-based
//   reference model tracks buffered beats, block position and the error flag.
module tb_add_round_key_stage;

  localparam int NR = 10;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic         in_start;
  logic [127:0] in_mix;
  logic [127:0] in_nomix;
  logic [127:0] in_key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic [3:0]   out_round;
  logic         out_last;
  logic         err_seq;

  add_round_key_stage #(.NR(NR)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_start  (in_start),
    .in_mix    (in_mix),
    .in_nomix  (in_nomix),
    .in_key    (in_key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_round (out_round),
    .out_last  (out_last),
    .err_seq   (err_seq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] d;
    int           r;
    logic         l;
  } ent_t;

  ent_t q[$];
  int   blk_pos;  // 0 = idle, else next expected round
  logic err_m;

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic check_outputs();
    chk("in_ready", in_ready, (q.size() < 2));
    chk("out_valid", out_valid, (q.size() != 0));
    chk("err_seq", err_seq, err_m);
    if (q.size() != 0) begin
      chk("out_data", out_data, q[0].d);
      chk("out_round", out_round, q[0].r);
      chk("out_last", out_last, q[0].l);
    end
  endtask

  // One clock cycle: check at negedge, drive, advance the model, wait edge
  task automatic step(input logic v, input logic s, input logic [127:0] m,
                      input logic [127:0] nm, input logic [127:0] k, input logic ordy);
    ent_t e;
    int   r;
    bit   do_push, do_pop;
    @(negedge clk);
    check_outputs();
    in_valid  = v;
    in_start  = s;
    in_mix    = m;
    in_nomix  = nm;
    in_key    = k;
    out_ready = ordy;
    do_push = v && (q.size() < 2);
    do_pop  = ordy && (q.size() != 0);
    if (do_pop) void'(q.pop_front());
    if (do_push) begin
      if (s || blk_pos == 0) begin
        if (!(s && blk_pos == 0)) err_m = 1'b1;
        r = 1;
      end else begin
        r = blk_pos;
      end
      blk_pos = (r == NR) ? 0 : r + 1;
      e.r = r;
      e.l = (r == NR);
      e.d = e.l ? (nm ^ k) : (m ^ k);
      q.push_back(e);
    end
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, '0, 1'b1);
  endtask

  // Mid-cycle reset pulse lasting about one clock
  task automatic pulse_reset();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_err_seq", err_seq, 1'b0);
    in_valid = 1'b0;
    q.delete();
    blk_pos = 0;
    err_m   = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [127:0] ones;
    logic [127:0] v;
    ones      = '1;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_start  = 1'b0;
    in_mix    = '0;
    in_nomix  = '0;
    in_key    = '0;
    out_ready = 1'b0;
    blk_pos   = 0;
    err_m     = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset_in_ready", in_ready, 1'b1);
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_out_data", out_data, '0);
    chk("reset_out_round", out_round, '0);
    chk("reset_out_last", out_last, 1'b0);
    chk("reset_err_seq", err_seq, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Full block, streaming, key all ones
    for (int i = 1; i <= NR; i++) begin
      v = 128'(i);
      step(1'b1, (i == 1), v, ~v, ones, 1'b1);
    end
    idle(2);

    // Backpressure: three pushes offered with downstream stalled
    step(1'b1, 1'b1, rnd128(), rnd128(), rnd128(), 1'b0);
    step(1'b1, 1'b0, rnd128(), rnd128(), rnd128(), 1'b0);
    v = rnd128();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, v, ~v, ones, 1'b0);

    // Full buffer then continuous push and pop
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, rnd128(), rnd128(), rnd128(), 1'b1);
    idle(3);

    // Reset with two beats buffered mid-block
    step(1'b1, 1'b1, rnd128(), rnd128(), rnd128(), 1'b0);
    step(1'b1, 1'b0, rnd128(), rnd128(), rnd128(), 1'b0);
    pulse_reset();
    step(1'b1, 1'b1, rnd128(), rnd128(), rnd128(), 1'b1);
    step(1'b1, 1'b0, rnd128(), rnd128(), rnd128(), 1'b1);
    idle(2);
    pulse_reset();

    // Restart inside a block at round 4
    for (int i = 1; i <= 5; i++) step(1'b1, (i == 1 || i == 4), rnd128(), rnd128(), rnd128(), 1'b1);
    idle(2);
    pulse_reset();

    // Non-start beat while idle
    step(1'b1, 1'b0, rnd128(), rnd128(), rnd128(), 1'b1);
    idle(2);
    pulse_reset();

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0),
           rnd128(), rnd128(), rnd128(), ($urandom_range(0, 2) != 0));
    end
    idle(3);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
